vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_pix_delay.sv | 34 +++
 rtl/vga_sync_gen.sv | 114 +++++++++++
 tb/tb_vga_sync_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter width and a region decoder
// used by the VGA sync generator.
package vga_timing_pkg;

  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    VISIBLE,
    FRONT,
    SYNC,
    BACK
  } region_e;

  // Regions run visible -> front porch -> sync -> back porch from position 0.
  function automatic region_e region_of(input logic [CNT_W-1:0] pos,
                                        input int active,
                                        input int fp,
                                        input int sync);
    int p;
    p = int'(pos);
    if (p < active)                  return VISIBLE;
    else if (p < active + fp)        return FRONT;
    else if (p < active + fp + sync) return SYNC;
    else                             return BACK;
  endfunction

endpackage

// File: rtl/vga_pix_delay.sv
// Tick-enabled shift register of STAGES entries; resets every entry to
// RST_VAL. STAGES = 0 is a plain wire.
module vga_pix_delay #(
  parameter int           W       = 3,
  parameter int           STAGES  = 0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (STAGES == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en};
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] sr [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < STAGES; i++) sr[i] <= RST_VAL;
      end else if (en) begin
        sr[0] <= d;
        for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[STAGES-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: clock divider to pixel tick, h/v counters,
// sync/visible decode and an optional tick-based delay on the sync bundle.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = 4,
  parameter int PIPE_DLY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             Hsync,
  output logic             Vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = 4;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_chk_total
    $error("vga_sync_gen: H_TOTAL or V_TOTAL exceeds the counter range");
  end
  if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_chk_div
    $error("vga_sync_gen: CLK_DIV must be 2..16");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_chk_dly
    $error("vga_sync_gen: PIPE_DLY must be 0..7");
  end

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h, v, h_nxt, v_nxt;
  logic             h_wrap, v_wrap;
  region_e          h_reg, v_reg;
  logic             hs_nxt, vs_nxt, vo_nxt;
  logic             hs0, vs0, vo0;
  logic [2:0]       dly_q;

  assign pix_tick = (div == DIV_LAST);
  assign h_wrap   = (h == H_LAST);
  assign v_wrap   = (v == V_LAST);

  // Next position on a tick; status is decoded from it so stage 0 lines up
  // with the counters it is loaded alongside.
  always_comb begin
    h_nxt = h_wrap ? '0 : h + CNT_W'(1);
    v_nxt = v;
    if (h_wrap) v_nxt = v_wrap ? '0 : v + CNT_W'(1);
  end

  assign h_reg  = region_of(h_nxt, H_ACTIVE, H_FP, H_SYNC);
  assign v_reg  = region_of(v_nxt, V_ACTIVE, V_FP, V_SYNC);
  assign hs_nxt = (h_reg != SYNC);
  assign vs_nxt = (v_reg != SYNC);
  assign vo_nxt = (h_reg == VISIBLE) && (v_reg == VISIBLE);

  // Counters start at the last position so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      h           <= H_LAST;
      v           <= V_LAST;
      hs0         <= 1'b1;
      vs0         <= 1'b1;
      vo0         <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= pix_tick ? '0 : div + DIV_W'(1);
      line_start  <= pix_tick && h_wrap;
      frame_start <= pix_tick && h_wrap && v_wrap;
      if (pix_tick) begin
        h   <= h_nxt;
        v   <= v_nxt;
        hs0 <= hs_nxt;
        vs0 <= vs_nxt;
        vo0 <= vo_nxt;
      end
    end
  end

  vga_pix_delay #(
    .W       (3),
    .STAGES  (PIPE_DLY),
    .RST_VAL (3'b110)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_tick),
    .d     ({hs0, vs0, vo0}),
    .q     (dly_q)
  );

  assign {Hsync, Vsync, video_on} = dly_q;
  assign pixel_x = h;
  assign pixel_y = v;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing (PIPE_DLY 0 and 3) plus a reduced
// geometry instance so whole frames fit in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_tick, a_vo, a_hs, a_vs, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_vo, b_hs, b_vs, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       s_tick, s_vo, s_hs, s_vs, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  vga_sync_gen u_a (
    .clk(clk), .rst_n(rst_n), .pix_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_vo), .Hsync(a_hs), .Vsync(a_vs), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_sync_gen #(.PIPE_DLY(3)) u_b (
    .clk(clk), .rst_n(rst_n), .pix_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_vo), .Hsync(b_hs), .Vsync(b_vs), .line_start(b_ls), .frame_start(b_fs)
  );

  // 25 x 11 positions, 3 clk per pixel: 75 clk per line, 825 clk per frame.
  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(3), .PIPE_DLY(0)
  ) u_s (
    .clk(clk), .rst_n(rst_n), .pix_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y),
    .video_on(s_vo), .Hsync(s_hs), .Vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Clock edges since the last reset release.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int   a_hs_fall[$], a_hs_rise[$], b_hs_fall[$], b_hs_rise[$];
  int   a_vo_rise[$], a_vo_fall[$], b_vo_rise[$], b_vo_fall[$];
  int   s_vs_fall[$], s_vs_rise[$];
  int   s_vo_cnt = 0, s_hs_lo = 0, s_vs_lo = 0, s_fs_cnt = 0, s_ls_cnt = 0;
  logic a_hs_q, b_hs_q, a_vo_q, b_vo_q, s_vs_q;
  logic mon_on = 1'b1;

  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      if (a_hs_q && !a_hs) a_hs_fall.push_back(cyc);
      if (!a_hs_q && a_hs) a_hs_rise.push_back(cyc);
      if (b_hs_q && !b_hs) b_hs_fall.push_back(cyc);
      if (!b_hs_q && b_hs) b_hs_rise.push_back(cyc);
      if (!a_vo_q && a_vo) a_vo_rise.push_back(cyc);
      if (a_vo_q && !a_vo) a_vo_fall.push_back(cyc);
      if (!b_vo_q && b_vo) b_vo_rise.push_back(cyc);
      if (b_vo_q && !b_vo) b_vo_fall.push_back(cyc);
      if (s_vs_q && !s_vs) s_vs_fall.push_back(cyc);
      if (!s_vs_q && s_vs) s_vs_rise.push_back(cyc);
      if (cyc >= 3 && cyc < 828) begin
        if (s_vo)  s_vo_cnt <= s_vo_cnt + 1;
        if (!s_hs) s_hs_lo  <= s_hs_lo + 1;
        if (!s_vs) s_vs_lo  <= s_vs_lo + 1;
      end
      if (cyc <= 7000) begin
        if (s_fs) s_fs_cnt <= s_fs_cnt + 1;
        if (s_ls) s_ls_cnt <= s_ls_cnt + 1;
      end
    end
    a_hs_q <= a_hs;
    b_hs_q <= b_hs;
    a_vo_q <= a_vo;
    b_vo_q <= b_vo;
    s_vs_q <= s_vs;
  end

  task automatic goto(input int e);
    int guard;
    guard = 0;
    while (cyc < e && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < e) chk("goto_timeout", cyc, e);
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_x", a_x, 799);
    chk("rst_y", a_y, 524);
    chk("rst_hsync", a_hs, 1);
    chk("rst_vsync", a_vs, 1);
    chk("rst_video_on", a_vo, 0);
    chk("rst_pix_tick", a_tick, 0);
    chk("rst_line_start", a_ls, 0);
    chk("rst_frame_start", a_fs, 0);
    chk("rst_dly3_hsync", b_hs, 1);
    chk("rst_dly3_video_on", b_vo, 0);
    rst_n = 1'b1;

    goto(1);
    chk("e1_tick", a_tick, 0);
    chk("e1_x", a_x, 799);
    goto(3);
    chk("e3_tick", a_tick, 1);
    chk("e3_x", a_x, 799);
    chk("e3_line_start", a_ls, 0);
    chk("s_e3_frame_start", s_fs, 1);
    goto(4);
    chk("e4_x", a_x, 0);
    chk("e4_y", a_y, 0);
    chk("e4_frame_start", a_fs, 1);
    chk("e4_line_start", a_ls, 1);
    chk("e4_tick", a_tick, 0);
    chk("e4_video_on", a_vo, 1);
    chk("e4_hsync", a_hs, 1);
    chk("e4_dly3_video_on", b_vo, 0);
    chk("s_e4_frame_start", s_fs, 0);
    goto(5);
    chk("e5_frame_start", a_fs, 0);
    chk("e5_line_start", a_ls, 0);

    goto(300);
    chk("s_pre_line_x", s_x, 24);
    chk("s_pre_line_y", s_y, 3);
    goto(303);
    chk("s_line_x", s_x, 0);
    chk("s_line_y", s_y, 4);
    chk("s_line_ls", s_ls, 1);
    chk("s_line_fs", s_fs, 0);
    goto(825);
    chk("s_pre_frame_x", s_x, 24);
    chk("s_pre_frame_y", s_y, 10);
    goto(828);
    chk("s_frame_x", s_x, 0);
    chk("s_frame_y", s_y, 0);
    chk("s_frame_fs", s_fs, 1);
    chk("s_frame_ls", s_ls, 1);

    goto(3200);
    chk("pre_line_x", a_x, 799);
    chk("pre_line_y", a_y, 0);
    goto(3204);
    chk("line_x", a_x, 0);
    chk("line_y", a_y, 1);
    chk("line_ls", a_ls, 1);
    chk("line_fs", a_fs, 0);

    goto(7000);
    chk("run_x", a_x, 149);
    chk("run_y", a_y, 2);
    chk("dly3_run_x", b_x, 149);
    chk("dly3_run_y", b_y, 2);
    goto(7002);
    chk("hs_fall_cnt", a_hs_fall.size(), 2);
    chk("hs_fall0", a_hs_fall[0], 2628);
    chk("hs_rise0", a_hs_rise[0], 3012);
    chk("hs_fall1", a_hs_fall[1], 5828);
    chk("dly3_hs_fall0", b_hs_fall[0], 2640);
    chk("dly3_hs_rise0", b_hs_rise[0], 3024);
    chk("vo_rise_cnt", a_vo_rise.size(), 3);
    chk("vo_rise0", a_vo_rise[0], 4);
    chk("vo_fall0", a_vo_fall[0], 2564);
    chk("dly3_vo_rise0", b_vo_rise[0], 16);
    chk("dly3_vo_fall0", b_vo_fall[0], 2576);
    chk("bp_to_visible", a_vo_rise[1] - a_hs_rise[0], 192);
    chk("s_vs_fall0", s_vs_fall[0], 528);
    chk("s_vs_rise0", s_vs_rise[0], 678);
    chk("s_vs_fall1", s_vs_fall[1], 1353);
    chk("s_video_cycles", s_vo_cnt, 288);
    chk("s_hsync_low", s_hs_lo, 132);
    chk("s_vsync_low", s_vs_lo, 150);
    chk("s_frame_pulses", s_fs_cnt, 9);
    chk("s_line_pulses", s_ls_cnt, 94);

    goto(7604);
    chk("mid_x", a_x, 300);
    chk("mid_y", a_y, 2);
    chk("mid_video_on", a_vo, 1);
    chk("mid_dly3_video_on", b_vo, 1);
    mon_on = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", a_x, 799);
    chk("arst_y", a_y, 524);
    chk("arst_hsync", a_hs, 1);
    chk("arst_vsync", a_vs, 1);
    chk("arst_video_on", a_vo, 0);
    chk("arst_dly3_video_on", b_vo, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    goto(3);
    chk("re_e3_tick", a_tick, 1);
    chk("re_e3_x", a_x, 799);
    goto(4);
    chk("re_e4_x", a_x, 0);
    chk("re_e4_y", a_y, 0);
    chk("re_e4_fs", a_fs, 1);
    chk("re_e4_ls", a_ls, 1);
    goto(15);
    chk("re_dly3_vo_e15", b_vo, 0);
    goto(16);
    chk("re_dly3_vo_e16", b_vo, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
